// File: rtl/aes128_arbiter_if.sv
// Per-requester job/response channel: a job handshake toward the arbiter and a result handshake back.
interface aes128_arbiter_if;
  logic         valid;
  logic         ready;
  logic [127:0] msg;
  logic [127:0] key;
  logic         enc;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;

  modport master (
    output valid, msg, key, enc, rsp_ready,
    input  ready, rsp_valid, rsp_data
  );

  modport slave (
    input  valid, msg, key, enc, rsp_ready,
    output ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/aes128_arbiter.sv
// Shares one AES128 core between two requesters, round-robin (fixed port-0 priority with AES_ARB_FIXED_PRIO_EN).
// Accept in T, core_start in T+1, response from T+2+CORE_LATENCY held until rsp_ready; no job accepted while busy.
module aes128_arbiter #(
  parameter int CORE_LATENCY = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  aes128_arbiter_if.slave      req0,
  aes128_arbiter_if.slave      req1,
  output logic                 core_start,
  output logic [127:0]         core_message_in,
  output logic [127:0]         core_key,
  output logic                 core_selCypher,
  input  logic [127:0]         core_message_out,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(CORE_LATENCY - 1);

  state_t       state, state_nxt;
  logic         owner;
  logic [7:0]   cnt;
  logic [127:0] result;
  logic         gnt;
  logic         tie_pick;
  logic         ready0, ready1;
  logic         accept;
  logic         rsp_hs;

`ifdef AES_ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
`else
  logic last_grant;

  // Resets to 1 so that port 0 wins the very first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last_grant <= 1'b1;
    else if (rsp_hs) last_grant <= owner;
  end

  assign tie_pick = ~last_grant;
`endif

  always_comb begin
    gnt = req1.valid;
    if (req0.valid && req1.valid) gnt = tie_pick;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    ready0     = 1'b0;
    ready1     = 1'b0;
    accept     = 1'b0;
    rsp_hs     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        ready0 = req0.valid && !gnt;
        ready1 = req1.valid && gnt;
        accept = ready0 || ready1;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (cnt == 8'd0) state_nxt = RESPOND;
      end
      RESPOND: begin
        // Only the owner's rsp_ready can complete the job.
        rsp_hs = owner ? req1.rsp_ready : req0.rsp_ready;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req0.ready     = ready0;
  assign req1.ready     = ready1;
  assign req0.rsp_valid = (state == RESPOND) && !owner;
  assign req1.rsp_valid = (state == RESPOND) && owner;
  assign req0.rsp_data  = result;
  assign req1.rsp_data  = result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner           <= 1'b0;
      cnt             <= 8'd0;
      result          <= '0;
      core_message_in <= '0;
      core_key        <= '0;
      core_selCypher  <= 1'b0;
    end else begin
      if (accept) begin
        owner           <= gnt;
        core_message_in <= gnt ? req1.msg : req0.msg;
        core_key        <= gnt ? req1.key : req0.key;
        core_selCypher  <= gnt ? req1.enc : req0.enc;
      end
      if (state == ISSUE) cnt <= CNT_LOAD;
      if (state == WAIT) begin
        if (cnt == 8'd0) result <= core_message_out;
        else             cnt    <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes128_arbiter.sv
// Directed bench for aes128_arbiter with a behavioural fixed-latency core model.
module tb_aes128_arbiter;
  localparam int CL = 31;
  localparam logic [127:0] PT  = 128'h328831E0435A3137F6309807A88DA234;
  localparam logic [127:0] K   = 128'h2B28AB097EAEF7CF15D2154F16A6883C;
  localparam logic [127:0] K2  = 128'h2B28AB097EAEF7CF15D2154F16A6883D;
  localparam logic [127:0] CT  = 128'h3902DC1925DC116A8409850B1DFB9732;
  localparam logic [127:0] BAD = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  localparam logic [127:0] M0  = 128'h11111111111111111111111111111111;
  localparam logic [127:0] M1  = 128'h22222222222222222222222222222222;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         core_start;
  logic [127:0] core_message_in, core_key, core_message_out;
  logic         core_selCypher;
  logic         busy;

  aes128_arbiter_if req0_if ();
  aes128_arbiter_if req1_if ();

  aes128_arbiter #(.CORE_LATENCY(CL)) dut (
    .clk              (clk),
    .reset            (reset),
    .req0             (req0_if),
    .req1             (req1_if),
    .core_start       (core_start),
    .core_message_in  (core_message_in),
    .core_key         (core_key),
    .core_selCypher   (core_selCypher),
    .core_message_out (core_message_out),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Known AES test vector in both directions; anything else maps to a simple reversible mix.
  function automatic logic [127:0] core_fn(input logic [127:0] m, input logic [127:0] k, input logic e);
    if (e && m == PT && k == K)       return CT;
    else if (!e && m == CT && k == K) return PT;
    else                              return m ^ k ^ {128{e}};
  endfunction

  int           cyc = 0;
  int           start_cyc = 0;
  int           n_starts = 0;
  logic         armed = 1'b0;
  logic [127:0] core_res = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) armed <= 1'b0;
    else if (core_start) begin
      armed     <= 1'b1;
      start_cyc <= cyc;
      core_res  <= core_fn(core_message_in, core_key, core_selCypher);
      n_starts  <= n_starts + 1;
    end
  end

  // Result is only correct from CL cycles after the start pulse; garbage before that.
  assign core_message_out = (armed && cyc >= start_cyc + CL) ? core_res : BAD;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [127:0] m, input logic [127:0] k, input logic e);
    if (p == 0) begin
      req0_if.valid = v; req0_if.msg = m; req0_if.key = k; req0_if.enc = e;
    end else begin
      req1_if.valid = v; req1_if.msg = m; req1_if.key = k; req1_if.enc = e;
    end
  endtask

  task automatic set_rsp_ready(input int p, input logic v);
    if (p == 0) req0_if.rsp_ready = v;
    else        req1_if.rsp_ready = v;
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_if.ready : req1_if.ready;
  endfunction

  function automatic logic rspv(input int p);
    return (p == 0) ? req0_if.rsp_valid : req1_if.rsp_valid;
  endfunction

  task automatic wait_accept(input int p, output int t, input string tag);
    #1;
    for (int i = 0; i < 50; i++) begin
      if (rdy(p)) break;
      tick();
    end
    check({tag, " accepted"}, rdy(p), 1);
    t = cyc;
    tick();
  endtask

  task automatic run_rsp(input int p, input int t_acc, input logic [127:0] exp, input string tag);
    int rise;
    logic other;
    rise  = -1;
    other = 1'b0;
    for (int i = 0; i < CL + 20; i++) begin
      if (rspv(1 - p)) other = 1'b1;
      if (rspv(p)) begin
        rise = cyc;
        break;
      end
      tick();
    end
    check({tag, " rsp rise cycle"}, rise, t_acc + 2 + CL);
    check({tag, " other port rsp_valid"}, other, 0);
    check({tag, " rsp_data"}, req0_if.rsp_data, exp);
    set_rsp_ready(p, 1'b1);
    tick();
    set_rsp_ready(p, 1'b0);
    check({tag, " rsp_valid drop"}, rspv(p), 0);
  endtask

  int t, s0, g;
  logic lost, chg, r1;
  logic [127:0] d0;
  int exp_g [4];

  initial begin
`ifdef AES_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    set_rsp_ready(0, 1'b0);
    set_rsp_ready(1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset core_start", core_start, 0);
    check("reset core_message_in", core_message_in, 0);
    check("reset core_key", core_key, 0);
    check("reset core_selCypher", core_selCypher, 0);
    check("reset rsp0_valid", req0_if.rsp_valid, 0);
    check("reset rsp1_valid", req1_if.rsp_valid, 0);
    check("reset rsp_data", req0_if.rsp_data, 0);
    reset = 1'b1;
    tick();

    // Port 0 encrypt
    set_req(0, 1'b1, PT, K, 1'b1);
    s0 = n_starts;
    wait_accept(0, t, "enc");
    set_req(0, 1'b0, '0, '0, 1'b0);
    check("enc core_start", core_start, 1);
    check("enc core_message_in", core_message_in, PT);
    check("enc core_key", core_key, K);
    check("enc core_selCypher", core_selCypher, 1);
    check("enc busy", busy, 1);
    tick();
    check("enc core_start one cycle", core_start, 0);
    run_rsp(0, t, CT, "enc");
    check("enc start count", n_starts - s0, 1);
    check("enc idle busy", busy, 0);

    // Port 1 decrypt
    set_req(1, 1'b1, CT, K, 1'b0);
    wait_accept(1, t, "dec");
    set_req(1, 1'b0, '0, '0, 1'b0);
    check("dec core_selCypher", core_selCypher, 0);
    run_rsp(1, t, PT, "dec");

    // Operands changed right after acceptance
    set_req(0, 1'b1, PT, K, 1'b1);
    wait_accept(0, t, "keychg");
    set_req(0, 1'b0, M1, K2, 1'b0);
    tick();
    check("keychg core_key", core_key, K);
    check("keychg core_message_in", core_message_in, PT);
    run_rsp(0, t, CT, "keychg");

    // Response stall with port 1 waiting and stray rsp1_ready
    set_req(0, 1'b1, PT, K, 1'b1);
    wait_accept(0, t, "stall");
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b1, CT, K, 1'b0);
    for (int i = 0; i < CL + 20; i++) begin
      if (rspv(0)) break;
      tick();
    end
    check("stall rsp0_valid", rspv(0), 1);
    set_rsp_ready(1, 1'b1);
    d0 = req0_if.rsp_data;
    lost = 1'b0; chg = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rspv(0)) lost = 1'b1;
      if (req0_if.rsp_data !== d0) chg = 1'b1;
      if (rdy(1)) r1 = 1'b1;
    end
    set_rsp_ready(1, 1'b0);
    check("stall rsp0_data", d0, CT);
    check("stall rsp0_valid dropped", lost, 0);
    check("stall rsp0_data changed", chg, 0);
    check("stall req1_ready seen", r1, 0);
    check("stall rsp1_valid", rspv(1), 0);
    set_rsp_ready(0, 1'b1);
    #1;
    check("stall req1_ready in handshake cycle", rdy(1), 0);
    tick();
    set_rsp_ready(0, 1'b0);
    #1;
    check("stall req1_ready after handshake", rdy(1), 1);
    t = cyc;
    tick();
    set_req(1, 1'b0, '0, '0, 1'b0);
    run_rsp(1, t, PT, "stall p1");

    // Both ports valid for four jobs
    set_req(0, 1'b1, M0, K, 1'b1);
    set_req(1, 1'b1, M1, K, 1'b1);
    for (int j = 0; j < 4; j++) begin
      #1;
      for (int i = 0; i < 50; i++) begin
        if (rdy(0) || rdy(1)) break;
        tick();
      end
      check($sformatf("arb single ready %0d", j), rdy(0) & rdy(1), 0);
      g = rdy(1) ? 1 : 0;
      check($sformatf("arb grant %0d", j), g, exp_g[j]);
      t = cyc;
      tick();
      run_rsp(g, t, core_fn(g ? M1 : M0, K, 1'b1), $sformatf("arb%0d", j));
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);

    // Reset during WAIT
    set_req(0, 1'b1, PT, K, 1'b1);
    wait_accept(0, t, "rst");
    set_req(0, 1'b0, '0, '0, 1'b0);
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("rst busy", busy, 0);
    check("rst core_start", core_start, 0);
    check("rst core_message_in", core_message_in, 0);
    check("rst core_key", core_key, 0);
    check("rst core_selCypher", core_selCypher, 0);
    check("rst rsp0_valid", rspv(0), 0);
    check("rst rsp_data", req0_if.rsp_data, 0);
    tick();
    reset = 1'b1;
    lost = 1'b0;
    for (int i = 0; i < CL + 20; i++) begin
      if (rspv(0) || rspv(1) || busy) lost = 1'b1;
      tick();
    end
    check("rst no response", lost, 0);
    set_req(0, 1'b1, PT, K, 1'b1);
    set_req(1, 1'b1, CT, K, 1'b0);
    #1;
    check("rst first tie req1_ready", rdy(1), 0);
    wait_accept(0, t, "post rst");
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    run_rsp(0, t, CT, "post rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
